query_patch_loader: RTL and testbench
=====================================

# query_patch_loader

Sequential stage between the 11-bit input FIFO (GPIO side) and the query-patch SRAM in the accelerator. It pops 11-bit words, packs every five into one 55-bit query patch, and writes each patch to the next query-memory address through the active-low SRAM port. A run starts with a pulse, covers a latched patch count, and ends with a one-cycle done pulse. One clock domain only.

## Interface
Parameters:
- DATA_WIDTH, 11: FIFO word width.
- WORDS_PER_PATCH, 5: words per patch.
- PATCH_WIDTH, 55: DATA_WIDTH*WORDS_PER_PATCH.
- ADDR_WIDTH, 9: query memory address width (512 patches).

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
  - clk  input  1  rising-edge clock.
  - rst_n  input  1  asynchronous active-low reset.
- Run control:
  - start  input  1  pulse; begins a run when idle.
  - num_patches  input  ADDR_WIDTH+1  patches in the run, 0..512; latched on accepted start.
  - busy  output  1  high whenever state != IDLE.
  - done  output  1  one-cycle pulse at end of run.
  - patch_count  output  ADDR_WIDTH+1  patches written in the current/last run.
- Input FIFO (first-word-fall-through):
  - fifo_rdata  input  DATA_WIDTH  head word, valid while fifo_rempty_n=1.
  - fifo_rempty_n  input  1  FIFO not empty.
  - fifo_deq  output  1  pop head this cycle.
- Query memory write port:
  - mem_csb0  output  1  active-low chip select.
  - mem_web0  output  1  active-low write enable.
  - mem_addr0  output  ADDR_WIDTH  write address.
  - mem_wpatch0  output  PATCH_WIDTH  write data.

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: on start=1:
  - latch num_patches;
  - clear the address counter, word counter and patch_count;
  - go to DONE if num_patches==0, else go to COLLECT.
- start is ignored in any state other than IDLE.
- COLLECT: fifo_deq = fifo_rempty_n (combinational; never asserted outside COLLECT).
  - Each pop stores word k (k = 0..4) into patch register bits [11k+10:11k]; the first word is least significant.
  - When word 4 pops, the word counter wraps to 0 and the state moves to WRITE.
  - FIFO empty: hold state and counters, no pop.
- WRITE (exactly one cycle):
  - mem_csb0=0, mem_web0=0, mem_addr0 = address counter, mem_wpatch0 = patch register.
  - Then increment the address counter and patch_count.
  - If patch_count+1 == latched count, go to DONE; else go to COLLECT.
- DONE: done=1 for one cycle, then IDLE.
- Outside WRITE: mem_csb0=1, mem_web0=1.
- mem_addr0 always shows the address counter; mem_wpatch0 always shows the patch register.
- num_patches==512: addresses 0..511 are written. The address counter wraps to 0 after the last write; this is harmless because the run ends.
- patch_count holds its final value after done, until the next accepted start.
- Reset (including mid-run):
  - state=IDLE, all counters and patch register = 0, busy=0, done=0, fifo_deq=0, mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wpatch0=0.
  - A partial patch is discarded and no write is issued.

## Timing
- start sampled at cycle 0 → COLLECT from cycle 1.
- With the FIFO never empty:
  - pops in cycles 1–5, write in cycle 6;
  - N patches: write j (1-based) occurs in cycle 6j;
  - done in cycle 6N+1, busy=0 from cycle 6N+2.
- Each empty cycle in COLLECT delays all later events by one cycle.
- Write latency: one cycle after the 5th pop of a patch.
- num_patches==0: done in cycle 1, no pops, no writes.
- start in the same cycle as done (state DONE): ignored. The earliest accepted restart is the first IDLE cycle.
- No combinational path from inputs to outputs except fifo_rempty_n → fifo_deq.

## Test plan
- Single patch:
  - Stimulus: num_patches=1; FIFO holds 0x001,0x002,0x003,0x004,0x005.
  - Required: one write, addr 0, data {0x005,0x004,0x003,0x002,0x001}; done in cycle 7; patch_count=1.
- FIFO bubbles:
  - Stimulus: num_patches=2; fifo_rempty_n low for 3 cycles mid-patch.
  - Required: fifo_deq stays 0 during the gap; writes at addr 0 and 1; done in cycle 16; no lost or duplicated word.
- Zero count:
  - Stimulus: num_patches=0.
  - Required: done in cycle 1; fifo_deq never 1; mem_csb0 stays 1.
- Full memory:
  - Stimulus: num_patches=512, streaming counter data.
  - Required: 512 writes at addresses 0..511 in order; patch_count=512; done in cycle 3073.
- Ignored start:
  - Stimulus: start pulsed during COLLECT and during DONE.
  - Required: no effect on counters, address or write count.
- Reset mid-run:
  - Stimulus: rst_n low after the 3rd pop of patch 2.
  - Required: outputs immediately at reset values. A new run of 1 patch then writes addr 0 with the 5 fresh words only.

Source files
------------

// File: rtl/query_patch_loader.sv
// query_patch_loader
//
// Sits between the 11-bit GPIO input FIFO and the query-patch SRAM. A run is
// started with a pulse on start. The run pops FIFO words five at a time,
// packs them into one 55-bit patch (first word least significant) and writes
// each patch to the next query-memory address through the active-low SRAM
// port. The run ends with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           pulse; begins a run when idle
//   num_patches     patches in the run (0..512), latched on an accepted start
//   busy            high whenever the loader is not idle
//   done            one-cycle pulse at the end of a run
//   patch_count     patches written in the current or last run
//   fifo_rdata      head word of the first-word-fall-through FIFO
//   fifo_rempty_n   FIFO not empty
//   fifo_deq        pop the FIFO head this cycle
//   mem_csb0        SRAM chip select, active low
//   mem_web0        SRAM write enable, active low
//   mem_addr0       SRAM write address
//   mem_wpatch0     SRAM write data (one packed patch)

`timescale 1ns/1ps

module query_patch_loader #(
  parameter int DATA_WIDTH      = 11,
  parameter int WORDS_PER_PATCH = 5,
  parameter int PATCH_WIDTH     = DATA_WIDTH * WORDS_PER_PATCH,
  parameter int ADDR_WIDTH      = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    num_patches,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    patch_count,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata,
  input  logic                   fifo_rempty_n,
  output logic                   fifo_deq,
  output logic                   mem_csb0,
  output logic                   mem_web0,
  output logic [ADDR_WIDTH-1:0]  mem_addr0,
  output logic [PATCH_WIDTH-1:0] mem_wpatch0
);

  localparam int CNT_W   = $clog2(WORDS_PER_PATCH);
  localparam int BASE_W  = $clog2(PATCH_WIDTH);
  localparam int COUNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_W-1:0]     target;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [CNT_W-1:0]       word_cnt;
  logic [COUNT_W-1:0]     count;
  logic [PATCH_WIDTH-1:0] patch;
  logic [BASE_W-1:0]      word_base;
  logic                   last_word;
  logic                   last_patch;

  // Bit offset of the slot the next popped word lands in.
  assign word_base  = BASE_W'(word_cnt) * BASE_W'(DATA_WIDTH);
  assign last_word  = (word_cnt == CNT_W'(WORDS_PER_PATCH - 1));
  // The count register is one bit wider than the address, so a run of 512
  // patches terminates correctly even though the address wraps to 0.
  assign last_patch = ((count + COUNT_W'(1)) == target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    fifo_deq   = 1'b0;
    mem_csb0   = 1'b1;
    mem_web0   = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (num_patches == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        // The only input-to-output combinational path: pop whenever the
        // FIFO has a word for us.
        fifo_deq = fifo_rempty_n;
        if (fifo_rempty_n && last_word) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        mem_csb0   = 1'b0;
        mem_web0   = 1'b0;
        state_next = last_patch ? DONE : COLLECT;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: run parameters, counters and the patch being assembled. A
  // reset mid-run wipes the partial patch so it can never be written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target   <= '0;
      addr     <= '0;
      word_cnt <= '0;
      count    <= '0;
      patch    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target   <= num_patches;
            addr     <= '0;
            word_cnt <= '0;
            count    <= '0;
          end
        end
        COLLECT: begin
          if (fifo_rempty_n) begin
            patch[word_base +: DATA_WIDTH] <= fifo_rdata;
            word_cnt <= last_word ? '0 : word_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          addr  <= addr + ADDR_WIDTH'(1);
          count <= count + COUNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr0   = addr;
  assign mem_wpatch0 = patch;
  assign patch_count = count;

endmodule

// File: tb/tb_query_patch_loader.sv
// tb_query_patch_loader
//
// Randomised self-checking bench for query_patch_loader. A queue models the
// input FIFO, a per-cycle availability table injects bubbles, and a reference
// model derives every expected SRAM write (address, packed data, cycle) and
// the done cycle from the word stream and the bubble table. A monitor pops
// the expected writes as the DUT issues them.

`timescale 1ns/1ps

module tb_query_patch_loader;

  localparam int DW  = 11;
  localparam int WPP = 5;
  localparam int PW  = DW * WPP;
  localparam int AW  = 9;
  localparam int AVAIL_DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_patches;
  logic          busy;
  logic          done;
  logic [AW:0]   patch_count;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rempty_n;
  logic          fifo_deq;
  logic          mem_csb0;
  logic          mem_web0;
  logic [AW-1:0] mem_addr0;
  logic [PW-1:0] mem_wpatch0;

  typedef struct {
    int            addr;
    logic [PW-1:0] data;
    int            cyc;
  } write_t;

  write_t        exp_q[$];
  write_t        mon_w;
  logic [DW-1:0] fifo_q[$];
  bit            avail[AVAIL_DEPTH];
  int            run_cyc;
  int            pop_count;
  int            exp_done;
  bit            deq_pending;
  int            n_checks;
  int            n_fails;

  query_patch_loader #(
    .DATA_WIDTH(DW),
    .WORDS_PER_PATCH(WPP),
    .PATCH_WIDTH(PW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_patches(num_patches),
    .busy(busy),
    .done(done),
    .patch_count(patch_count),
    .fifo_rdata(fifo_rdata),
    .fifo_rempty_n(fifo_rempty_n),
    .fifo_deq(fifo_deq),
    .mem_csb0(mem_csb0),
    .mem_web0(mem_web0),
    .mem_addr0(mem_addr0),
    .mem_wpatch0(mem_wpatch0)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic bit avail_at(input int c);
    return (c >= 0 && c < AVAIL_DEPTH) ? avail[c] : 1'b1;
  endfunction

  // One clock cycle: account for the pop that happened on the rising edge,
  // then present the FIFO head for the next cycle on the falling edge.
  task automatic tick();
    @(posedge clk);
    run_cyc++;
    if (deq_pending && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_count++;
    end
    @(negedge clk);
    if (fifo_q.size() > 0 && avail_at(run_cyc)) begin
      fifo_rempty_n = 1'b1;
      fifo_rdata    = fifo_q[0];
    end else begin
      fifo_rempty_n = 1'b0;
      fifo_rdata    = DW'($urandom);
    end
    #1;
    deq_pending = rst_n && fifo_deq;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_busy"},     64'(busy),        64'd0);
    check_output({tag, "_done"},     64'(done),        64'd0);
    check_output({tag, "_deq"},      64'(fifo_deq),    64'd0);
    check_output({tag, "_csb"},      64'(mem_csb0),    64'd1);
    check_output({tag, "_web"},      64'(mem_web0),    64'd1);
    check_output({tag, "_addr"},     64'(mem_addr0),   64'd0);
    check_output({tag, "_wpatch"},   64'(mem_wpatch0), 64'd0);
    check_output({tag, "_pcount"},   64'(patch_count), 64'd0);
  endtask

  // Runs one transaction of n patches. data_mode 1 streams 1,2,3,...; 0 is
  // random. Words arrive with bubble_pct percent empty cycles plus an
  // optional forced gap. extra_words sit behind the run and must survive.
  // poke_start pulses start during COLLECT and during DONE. reset_pops > 0
  // pulls rst_n low right after that many pops and abandons the run.
  task automatic apply_stimulus(input int n, input int data_mode, input int bubble_pct,
                                input int gap_start, input int gap_len, input int extra_words,
                                input bit poke_start, input int reset_pops);
    logic [DW-1:0] words[$];
    logic [DW-1:0] w;
    logic [PW-1:0] patch;
    write_t        e;
    int            c;
    int            got;
    bit            seen_done;

    for (int i = 0; i < n * WPP; i++) begin
      w = (data_mode == 1) ? DW'(i + 1) : DW'($urandom);
      words.push_back(w);
      fifo_q.push_back(w);
    end
    for (int i = 0; i < extra_words; i++) begin
      fifo_q.push_back(DW'($urandom));
    end
    for (int i = 0; i < AVAIL_DEPTH; i++) begin
      avail[i] = (int'($urandom_range(99)) >= bubble_pct);
      if (i >= gap_start && i < gap_start + gap_len) avail[i] = 1'b0;
    end

    // Reference: each patch needs five available cycles, then one write
    // cycle; the patch is the five words with the first one lowest.
    c = 1;
    for (int p = 0; p < n; p++) begin
      got = 0;
      while (got < WPP) begin
        if (avail_at(c)) got++;
        c++;
      end
      patch = '0;
      for (int k = WPP - 1; k >= 0; k--) begin
        patch = (patch << DW) | PW'(words[p * WPP + k]);
      end
      e.addr = p % 512;
      e.data = patch;
      e.cyc  = c;
      exp_q.push_back(e);
      c++;
    end
    exp_done = c;

    run_cyc     = 0;
    pop_count   = 0;
    start       = 1'b1;
    num_patches = (AW + 1)'(n);
    seen_done   = 1'b0;

    for (int i = 0; i < 8000 && !seen_done; i++) begin
      tick();
      start = 1'b0;
      if (poke_start && run_cyc == 2) begin
        start       = 1'b1;
        num_patches = 10'd7;
      end
      if (reset_pops > 0 && pop_count == reset_pops) begin
        rst_n       = 1'b0;
        deq_pending = 1'b0;
        start       = 1'b0;
        #1;
        check_reset_state("midrun_reset");
        exp_q.delete();
        fifo_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      if (done) seen_done = 1'b1;
    end

    check_output("done_seen",   64'(seen_done),   64'd1);
    check_output("done_cycle",  64'(run_cyc),     64'(exp_done));
    check_output("patch_count", 64'(patch_count), 64'(n));
    if (poke_start) begin
      start       = 1'b1;
      num_patches = 10'd5;
    end
    tick();
    start = 1'b0;
    check_output("done_pulse_len",   64'(done),          64'd0);
    check_output("busy_after_done",  64'(busy),          64'd0);
    check_output("count_held",       64'(patch_count),   64'(n));
    check_output("writes_missing",   64'(exp_q.size()),  64'd0);
    check_output("fifo_words_left",  64'(fifo_q.size()), 64'(extra_words));
    fifo_q.delete();
    tick();
  endtask

  // Monitor: every SRAM write must match the next expected write, and the
  // FIFO must never be popped while it reports empty.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (!mem_csb0 || !mem_web0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr0, mem_wpatch0);
        end else begin
          mon_w = exp_q.pop_front();
          check_output("write_strobes", 64'({mem_csb0, mem_web0}), 64'd0);
          check_output("write_addr",    64'(mem_addr0),   64'(mon_w.addr));
          check_output("write_data",    64'(mem_wpatch0), 64'(mon_w.data));
          check_output("write_cycle",   64'(run_cyc),     64'(mon_w.cyc));
        end
      end
      if (!fifo_rempty_n) begin
        check_output("deq_when_empty", 64'(fifo_deq), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation still running, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    run_cyc       = 0;
    pop_count     = 0;
    deq_pending   = 1'b0;
    rst_n         = 1'b0;
    start         = 1'b0;
    num_patches   = '0;
    fifo_rdata    = '0;
    fifo_rempty_n = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_reset_state("init");
    rst_n = 1'b1;
    tick();

    $display("[TB] single patch");
    apply_stimulus(1, 1, 0, 0, 0, 0, 1'b0, 0);

    $display("[TB] fifo bubbles");
    apply_stimulus(2, 0, 0, 3, 3, 0, 1'b0, 0);

    $display("[TB] zero count");
    apply_stimulus(0, 0, 0, 0, 0, 5, 1'b0, 0);

    $display("[TB] ignored start");
    apply_stimulus(2, 0, 0, 0, 0, 0, 1'b1, 0);

    $display("[TB] random runs");
    for (int r = 0; r < 6; r++) begin
      apply_stimulus(int'($urandom_range(1, 6)), 0, 30, 0, 0, 0, 1'b0, 0);
    end

    $display("[TB] full memory");
    apply_stimulus(512, 1, 0, 0, 0, 0, 1'b0, 0);

    $display("[TB] reset mid-run");
    apply_stimulus(3, 1, 0, 0, 0, 0, 1'b0, 8);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
